// File: rtl/cpu64_mem_obi_arbiter.sv
// Two-to-one round-robin OBI arbiter that merges the instruction and data ports onto one memory bus.
// An in-order route FIFO records each accepted transaction so its response returns to the issuing port.
module cpu64_mem_obi_arbiter #(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int MAX_OUTST = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         i_req_i,
    input  logic                         i_we_i,
    input  logic [DATA_W/8-1:0]          i_be_i,
    input  logic [ADDR_W-1:0]            i_addr_i,
    input  logic [DATA_W-1:0]            i_wdata_i,
    output logic                         i_gnt_o,
    output logic                         i_rvalid_o,
    output logic [DATA_W-1:0]            i_rdata_o,
    input  logic                         d_req_i,
    input  logic                         d_we_i,
    input  logic [DATA_W/8-1:0]          d_be_i,
    input  logic [ADDR_W-1:0]            d_addr_i,
    input  logic [DATA_W-1:0]            d_wdata_i,
    output logic                         d_gnt_o,
    output logic                         d_rvalid_o,
    output logic [DATA_W-1:0]            d_rdata_o,
    output logic                         m_req_o,
    output logic                         m_we_o,
    output logic [DATA_W/8-1:0]          m_be_o,
    output logic [ADDR_W-1:0]            m_addr_o,
    output logic [DATA_W-1:0]            m_wdata_o,
    input  logic                         m_gnt_i,
    input  logic                         m_rvalid_i,
    input  logic [DATA_W-1:0]            m_rdata_i,
    output logic [$clog2(MAX_OUTST):0]   outst_o,
    output logic                         err_o
);

    localparam int CNT_W = $clog2(MAX_OUTST) + 1;
    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int BE_W  = DATA_W / 8;

    // Port encoding used by sel, last, lock id and the route FIFO
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // Pointer increment with explicit wrap so a depth of one also works
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_OUTST - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = p + PTR_W'(1);
        end
    endfunction

    logic                 fifo_r [MAX_OUTST];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;
    logic                 lock_r;
    logic                 lock_id_r;
    logic                 last_r;
    logic                 err_r;

    logic                 sel_s;
    logic                 full_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 head_s;

    assign full_s = (count_r == CNT_W'(MAX_OUTST));
    assign head_s = fifo_r[rd_ptr_r];

    // Winner selection: a stalled request stays locked, otherwise round-robin on ties
    always_comb begin
        sel_s = PORT_I;
        if (lock_r) begin
            sel_s = lock_id_r;
        end else if (i_req_i && !d_req_i) begin
            sel_s = PORT_I;
        end else if (d_req_i && !i_req_i) begin
            sel_s = PORT_D;
        end else if (i_req_i && d_req_i) begin
            sel_s = ~last_r;
        end else begin
            sel_s = PORT_I;
        end
    end

    // External request mux, grants and response routing
    always_comb begin
        m_req_o    = (i_req_i | d_req_i) & ~full_s;
        m_we_o     = 1'b0;
        m_be_o     = '0;
        m_addr_o   = '0;
        m_wdata_o  = '0;
        i_gnt_o    = 1'b0;
        d_gnt_o    = 1'b0;
        i_rvalid_o = 1'b0;
        d_rvalid_o = 1'b0;
        push_s     = m_req_o & m_gnt_i;
        pop_s      = m_rvalid_i & (count_r != CNT_W'(0));
        if (m_req_o) begin
            if (sel_s == PORT_D) begin
                m_we_o    = d_we_i;
                m_be_o    = d_be_i;
                m_addr_o  = d_addr_i;
                m_wdata_o = d_wdata_i;
                d_gnt_o   = m_gnt_i;
            end else begin
                m_we_o    = i_we_i;
                m_be_o    = i_be_i;
                m_addr_o  = i_addr_i;
                m_wdata_o = i_wdata_i;
                i_gnt_o   = m_gnt_i;
            end
        end else begin
            m_we_o = 1'b0;
        end
        if (pop_s) begin
            i_rvalid_o = (head_s == PORT_I);
            d_rvalid_o = (head_s == PORT_D);
        end else begin
            i_rvalid_o = 1'b0;
        end
    end

    assign i_rdata_o = m_rdata_i;
    assign d_rdata_o = m_rdata_i;

    // Route FIFO storage and pointers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < MAX_OUTST; k++) begin
                fifo_r[k] <= 1'b0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                fifo_r[wr_ptr_r] <= sel_s;
                wr_ptr_r         <= ptr_next(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
        end
    end

    // Outstanding transaction counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_r <= '0;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Arbitration state: lock holds a stalled request stable, last drives the round-robin
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_r    <= 1'b0;
            lock_id_r <= PORT_I;
            last_r    <= PORT_D;
        end else if (push_s) begin
            lock_r <= 1'b0;
            last_r <= sel_s;
        end else if (m_req_o) begin
            lock_r    <= 1'b1;
            lock_id_r <= sel_s;
        end else begin
            lock_r <= lock_r;
        end
    end

    // Sticky error on a response that has no matching transaction
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_r <= 1'b0;
        end else if (m_rvalid_i && (count_r == CNT_W'(0))) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign outst_o = count_r;
    assign err_o   = err_r;

endmodule

// File: tb/tb_cpu64_mem_obi_arbiter.sv
// Directed self-checking bench for cpu64_mem_obi_arbiter with default parameters (MAX_OUTST = 4).
module tb_cpu64_mem_obi_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        i_req_i, i_we_i, d_req_i, d_we_i;
    logic [7:0]  i_be_i, d_be_i, m_be_o;
    logic [63:0] i_addr_i, i_wdata_i, d_addr_i, d_wdata_i;
    logic        i_gnt_o, i_rvalid_o, d_gnt_o, d_rvalid_o;
    logic [63:0] i_rdata_o, d_rdata_o;
    logic        m_req_o, m_we_o, m_gnt_i, m_rvalid_i;
    logic [63:0] m_addr_o, m_wdata_o, m_rdata_i;
    logic [2:0]  outst_o;
    logic        err_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    cpu64_mem_obi_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .i_req_i(i_req_i), .i_we_i(i_we_i), .i_be_i(i_be_i), .i_addr_i(i_addr_i), .i_wdata_i(i_wdata_i),
        .i_gnt_o(i_gnt_o), .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .m_req_o(m_req_o), .m_we_o(m_we_o), .m_be_o(m_be_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
        .m_gnt_i(m_gnt_i), .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i),
        .outst_o(outst_o), .err_o(err_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        i_req_i = 1'b0; i_we_i = 1'b0; i_be_i = 8'h00; i_addr_i = 64'h0; i_wdata_i = 64'h0;
        d_req_i = 1'b0; d_we_i = 1'b0; d_be_i = 8'h00; d_addr_i = 64'h0; d_wdata_i = 64'h0;
        m_gnt_i = 1'b0; m_rvalid_i = 1'b0; m_rdata_i = 64'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (m_req_o !== 1'b0) begin bad++; $display("FAIL reset_m_req got=%0b exp=0", m_req_o); end
        total++; if ({i_gnt_o, d_gnt_o, i_rvalid_o, d_rvalid_o} !== 4'b0000) begin bad++; $display("FAIL reset_gnt_rvalid got=%b exp=0000", {i_gnt_o, d_gnt_o, i_rvalid_o, d_rvalid_o}); end
        total++; if (outst_o !== 3'd0) begin bad++; $display("FAIL reset_outst got=%0d exp=0", outst_o); end
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", err_o); end
        total++; if (m_addr_o !== 64'h0) begin bad++; $display("FAIL reset_m_addr got=%h exp=0", m_addr_o); end
    endtask

    // Both ports request with grant held: I, D, I, D, then full; then drain and refill.
    task automatic test_round_robin_full();
        do_reset();
        i_req_i = 1'b1; d_req_i = 1'b1; i_addr_i = 64'h100; d_addr_i = 64'h200; m_gnt_i = 1'b1;
        #1;
        total++; if ({i_gnt_o, d_gnt_o} !== 2'b10 || m_addr_o !== 64'h100) begin bad++; $display("FAIL rr_c0 gnt=%b addr=%h exp 10/100", {i_gnt_o, d_gnt_o}, m_addr_o); end
        tick();
        total++; if ({i_gnt_o, d_gnt_o} !== 2'b01 || m_addr_o !== 64'h200 || outst_o !== 3'd1) begin bad++; $display("FAIL rr_c1 gnt=%b addr=%h outst=%0d exp 01/200/1", {i_gnt_o, d_gnt_o}, m_addr_o, outst_o); end
        tick();
        total++; if ({i_gnt_o, d_gnt_o} !== 2'b10 || outst_o !== 3'd2) begin bad++; $display("FAIL rr_c2 gnt=%b outst=%0d exp 10/2", {i_gnt_o, d_gnt_o}, outst_o); end
        tick();
        total++; if ({i_gnt_o, d_gnt_o} !== 2'b01 || outst_o !== 3'd3) begin bad++; $display("FAIL rr_c3 gnt=%b outst=%0d exp 01/3", {i_gnt_o, d_gnt_o}, outst_o); end
        tick();
        total++; if (outst_o !== 3'd4 || m_req_o !== 1'b0 || {i_gnt_o, d_gnt_o} !== 2'b00) begin bad++; $display("FAIL full_block outst=%0d m_req=%0b gnt=%b exp 4/0/00", outst_o, m_req_o, {i_gnt_o, d_gnt_o}); end
        d_req_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 64'h11;
        #1;
        total++; if (m_req_o !== 1'b0) begin bad++; $display("FAIL full_pop_block m_req=%0b exp 0", m_req_o); end
        total++; if ({i_rvalid_o, d_rvalid_o} !== 2'b10 || i_rdata_o !== 64'h11) begin bad++; $display("FAIL full_pop_route rv=%b rdata=%h exp 10/11", {i_rvalid_o, d_rvalid_o}, i_rdata_o); end
        tick();
        m_rvalid_i = 1'b0;
        #1;
        total++; if (outst_o !== 3'd3 || i_gnt_o !== 1'b1 || m_addr_o !== 64'h100) begin bad++; $display("FAIL refill outst=%0d i_gnt=%0b addr=%h exp 3/1/100", outst_o, i_gnt_o, m_addr_o); end
        tick();
        i_req_i = 1'b0;
        #1;
        total++; if (outst_o !== 3'd4) begin bad++; $display("FAIL refill_cnt outst=%0d exp 4", outst_o); end
        // FIFO now holds D, I, D, I
        for (int k = 0; k < 4; k++) begin
            m_rvalid_i = 1'b1; m_rdata_i = 64'(k + 32);
            #1;
            total++;
            if (d_rvalid_o !== ((k % 2) == 0) || i_rvalid_o !== ((k % 2) == 1) || d_rdata_o !== 64'(k + 32)) begin
                bad++; $display("FAIL drain_%0d rv_i=%0b rv_d=%0b rdata=%h", k, i_rvalid_o, d_rvalid_o, d_rdata_o);
            end
            tick();
        end
        m_rvalid_i = 1'b0;
        #1;
        total++; if (outst_o !== 3'd0 || err_o !== 1'b0) begin bad++; $display("FAIL drain_end outst=%0d err=%0b exp 0/0", outst_o, err_o); end
    endtask

    // D stalls for three cycles while I joins; D's request must stay presented.
    task automatic test_lock();
        do_reset();
        d_req_i = 1'b1; d_addr_i = 64'h300; d_we_i = 1'b1; d_be_i = 8'hF0; d_wdata_i = 64'hDEAD;
        #1;
        total++; if (m_req_o !== 1'b1 || m_addr_o !== 64'h300 || m_be_o !== 8'hF0 || m_we_o !== 1'b1 || m_wdata_o !== 64'hDEAD || d_gnt_o !== 1'b0) begin
            bad++; $display("FAIL lock_c0 req=%0b addr=%h be=%h we=%0b wdata=%h gnt=%0b", m_req_o, m_addr_o, m_be_o, m_we_o, m_wdata_o, d_gnt_o); end
        tick();
        i_req_i = 1'b1; i_addr_i = 64'h400;
        for (int c = 1; c < 4; c++) begin
            #1;
            total++; if (m_addr_o !== 64'h300 || i_gnt_o !== 1'b0 || d_gnt_o !== 1'b0) begin bad++; $display("FAIL lock_hold_c%0d addr=%h i_gnt=%0b d_gnt=%0b exp 300/0/0", c, m_addr_o, i_gnt_o, d_gnt_o); end
            tick();
        end
        m_gnt_i = 1'b1;
        #1;
        total++; if (d_gnt_o !== 1'b1 || i_gnt_o !== 1'b0 || m_addr_o !== 64'h300) begin bad++; $display("FAIL lock_grant d_gnt=%0b i_gnt=%0b addr=%h exp 1/0/300", d_gnt_o, i_gnt_o, m_addr_o); end
        tick();
        d_req_i = 1'b0;
        #1;
        total++; if (i_gnt_o !== 1'b1 || m_addr_o !== 64'h400 || outst_o !== 3'd1) begin bad++; $display("FAIL lock_next i_gnt=%0b addr=%h outst=%0d exp 1/400/1", i_gnt_o, m_addr_o, outst_o); end
        tick();
        idle_inputs();
        #1;
        total++; if (outst_o !== 3'd2 || m_req_o !== 1'b0 || m_addr_o !== 64'h0) begin bad++; $display("FAIL lock_end outst=%0d m_req=%0b addr=%h exp 2/0/0", outst_o, m_req_o, m_addr_o); end
    endtask

    // Outstanding I, D, D answered with 0xA, 0xB, 0xC.
    task automatic test_resp_order();
        logic [63:0] data_v [3];
        logic [1:0]  rv_v   [3];
        data_v[0] = 64'hA; data_v[1] = 64'hB; data_v[2] = 64'hC;
        rv_v[0] = 2'b10; rv_v[1] = 2'b01; rv_v[2] = 2'b01;
        do_reset();
        m_gnt_i = 1'b1; i_req_i = 1'b1;
        tick();
        i_req_i = 1'b0; d_req_i = 1'b1;
        tick();
        tick();
        idle_inputs();
        #1;
        total++; if (outst_o !== 3'd3) begin bad++; $display("FAIL order_cnt outst=%0d exp 3", outst_o); end
        for (int k = 0; k < 3; k++) begin
            m_rvalid_i = 1'b1; m_rdata_i = data_v[k];
            #1;
            total++; if ({i_rvalid_o, d_rvalid_o} !== rv_v[k] || i_rdata_o !== data_v[k] || d_rdata_o !== data_v[k]) begin
                bad++; $display("FAIL order_%0d rv=%b exp %b rdata_i=%h rdata_d=%h exp %h", k, {i_rvalid_o, d_rvalid_o}, rv_v[k], i_rdata_o, d_rdata_o, data_v[k]); end
            tick();
        end
        m_rvalid_i = 1'b0;
        #1;
        total++; if (outst_o !== 3'd0 || {i_rvalid_o, d_rvalid_o} !== 2'b00) begin bad++; $display("FAIL order_end outst=%0d rv=%b exp 0/00", outst_o, {i_rvalid_o, d_rvalid_o}); end
    endtask

    // Accept and response in the same cycle at count 2.
    task automatic test_back_to_back();
        do_reset();
        m_gnt_i = 1'b1; i_req_i = 1'b1; d_req_i = 1'b1;
        tick();
        tick();
        d_req_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 64'h55;
        #1;
        total++; if (outst_o !== 3'd2 || i_gnt_o !== 1'b1 || i_rvalid_o !== 1'b1 || d_rvalid_o !== 1'b0) begin
            bad++; $display("FAIL b2b_same outst=%0d i_gnt=%0b rv=%b exp 2/1/10", outst_o, i_gnt_o, {i_rvalid_o, d_rvalid_o}); end
        tick();
        i_req_i = 1'b0; m_rdata_i = 64'h66;
        #1;
        total++; if (outst_o !== 3'd2 || d_rvalid_o !== 1'b1 || i_rvalid_o !== 1'b0 || d_rdata_o !== 64'h66) begin
            bad++; $display("FAIL b2b_next outst=%0d rv=%b rdata=%h exp 2/01/66", outst_o, {i_rvalid_o, d_rvalid_o}, d_rdata_o); end
        tick();
        m_rdata_i = 64'h77;
        #1;
        total++; if ({i_rvalid_o, d_rvalid_o} !== 2'b10 || outst_o !== 3'd1) begin bad++; $display("FAIL b2b_last rv=%b outst=%0d exp 10/1", {i_rvalid_o, d_rvalid_o}, outst_o); end
        tick();
        idle_inputs();
        #1;
        total++; if (outst_o !== 3'd0) begin bad++; $display("FAIL b2b_end outst=%0d exp 0", outst_o); end
    endtask

    // Stray response with nothing outstanding sets the sticky error.
    task automatic test_err();
        do_reset();
        m_rvalid_i = 1'b1; m_rdata_i = 64'h99;
        #1;
        total++; if ({i_rvalid_o, d_rvalid_o} !== 2'b00) begin bad++; $display("FAIL err_no_rvalid rv=%b exp 00", {i_rvalid_o, d_rvalid_o}); end
        tick();
        m_rvalid_i = 1'b0;
        #1;
        total++; if (err_o !== 1'b1 || outst_o !== 3'd0) begin bad++; $display("FAIL err_set err=%0b outst=%0d exp 1/0", err_o, outst_o); end
        tick();
        tick();
        total++; if (err_o !== 1'b1) begin bad++; $display("FAIL err_sticky err=%0b exp 1", err_o); end
        do_reset();
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL err_clear err=%0b exp 0", err_o); end
    endtask

    initial begin
        rst_i = 1'b1;
        idle_inputs();
        test_reset();
        test_round_robin_full();
        test_lock();
        test_resp_order();
        test_back_to_back();
        test_err();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
